// File: rtl/dmem_pkg.sv
// Shared definitions for the multi-cycle data-memory responder.
//   state_t        : FSM encoding (IDLE=0, WAIT=1, RESP=2)
//   CNT_W          : width of the wait-state counter (covers LATENCY up to 15)
//   DEF_DATA_W     : default data/address width
//   DEF_DEPTH_LOG2 : default log2 of the word count
package dmem_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_DEPTH_LOG2 = 8;
  localparam int CNT_W          = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed register file backing the responder.
// Ports:
//   clk   : clock, rising edge
//   we    : write enable, array[waddr] <= wdata at the rising edge
//   waddr : write word index
//   wdata : write data
//   raddr : read word index
//   rdata : combinational read data, array[raddr]
// Contents are deliberately not reset.
module dmem_array #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage. One request is
// accepted in IDLE, LATENCY-1 wait states follow, and the RESP cycle
// acknowledges (and commits a write at its closing edge).
//
// Handshake: i_req is a level request. It is taken in the IDLE cycle where
// it is high; inputs are captured there and ignored until the access ends.
// o_ack pulses for one cycle exactly LATENCY cycles after acceptance, and
// o_stall = i_req & ~o_ack holds the pipeline until that cycle. One IDLE
// cycle always separates two accesses.
//
// Ports:
//   i_clk, i_rst_n : clock (rising) and asynchronous active-low reset
//   i_req, i_we    : request valid, 1 = write / 0 = read
//   i_addr         : byte address, word index = i_addr[DEPTH_LOG2+1:2]
//   i_wdata        : write data
//   o_ack          : access complete (one-cycle pulse)
//   o_rdata        : read data during a read ack, holds its value afterwards
//   o_stall        : pipeline hold request
//   o_busy         : FSM is not IDLE
//   o_misalign     : (DMEM_ALIGN_CHECK_EN only) ack of a misaligned access;
//                    a misaligned write is dropped
//   o_state        : current FSM state, for debug/observation
//
// Optional feature macro: DMEM_ALIGN_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int LATENCY    = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [DATA_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_ack,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_stall,
  output logic              o_busy,
`ifdef DMEM_ALIGN_CHECK_EN
  output logic              o_misalign,
`endif
  output logic [1:0]        o_state
);

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("dmem_responder: LATENCY must be in 1..15");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    accept;
  logic                    we_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [DATA_W-1:0]       rdata_q;
  logic [DATA_W-1:0]       arr_rdata;
  logic                    commit;
  logic                    unused_addr;

  assign unused_addr = ^i_addr;

  // Next-state logic. The counter is loaded with LATENCY-1 so that the last
  // WAIT cycle is the one where it reads 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_req) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Holding registers for the accepted request, plus the read-data hold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= i_we;
        idx_q   <= i_addr[DEPTH_LOG2+1:2];
        wdata_q <= i_wdata;
      end
      if (state_q == ST_RESP && !we_q) begin
        rdata_q <= arr_rdata;
      end
    end
  end

  assign o_ack   = (state_q == ST_RESP);
  assign o_busy  = (state_q != ST_IDLE);
  assign o_stall = i_req & ~o_ack;
  assign o_state = state_q;
  // Read data is presented straight from the array in the RESP cycle and
  // held afterwards, so a read right after a write sees the committed value.
  assign o_rdata = (o_ack && !we_q) ? arr_rdata : rdata_q;

`ifdef DMEM_ALIGN_CHECK_EN
  logic mis_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mis_q <= 1'b0;
    end else if (accept) begin
      mis_q <= (i_addr[1:0] != 2'b00);
    end
  end

  assign o_misalign = o_ack & mis_q;
  assign commit     = o_ack & we_q & ~mis_q;
`else
  assign commit     = o_ack & we_q;
`endif

  dmem_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (i_clk),
    .we    (commit),
    .waddr (idx_q),
    .wdata (wdata_q),
    .raddr (idx_q),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: main instance at LATENCY=2 checked every cycle
// against a transaction-level model, plus LATENCY=1 and LATENCY=4 instances
// for latency/spacing measurement.
module tb_dmem_responder;

  localparam int L = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic        ack, stall, busy;
  logic [31:0] rdata;
  logic [1:0]  st_main;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        mis, mis_a, mis_b;
`endif

  dmem_responder #(.DATA_W(32), .DEPTH_LOG2(8), .LATENCY(L)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_addr(addr),
    .i_wdata(wdata), .o_ack(ack), .o_rdata(rdata), .o_stall(stall),
    .o_busy(busy),
`ifdef DMEM_ALIGN_CHECK_EN
    .o_misalign(mis),
`endif
    .o_state(st_main)
  );

  // ---------------- LATENCY=1 and LATENCY=4 instances ----------------
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [31:0] zero32 = '0;
  logic        ack_a, stall_a, busy_a, ack_b, stall_b, busy_b;
  logic [31:0] rdata_a, rdata_b;
  logic [1:0]  st_a, st_b;

  dmem_responder #(.DATA_W(32), .DEPTH_LOG2(8), .LATENCY(1)) u_l1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req_a), .i_we(1'b0), .i_addr(zero32),
    .i_wdata(zero32), .o_ack(ack_a), .o_rdata(rdata_a), .o_stall(stall_a),
    .o_busy(busy_a),
`ifdef DMEM_ALIGN_CHECK_EN
    .o_misalign(mis_a),
`endif
    .o_state(st_a)
  );

  dmem_responder #(.DATA_W(32), .DEPTH_LOG2(8), .LATENCY(4)) u_l4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req_b), .i_we(1'b0), .i_addr(zero32),
    .i_wdata(zero32), .o_ack(ack_b), .o_rdata(rdata_b), .o_stall(stall_b),
    .o_busy(busy_b),
`ifdef DMEM_ALIGN_CHECK_EN
    .o_misalign(mis_b),
`endif
    .o_state(st_b)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + scoreboard ----------------
  // One access in flight at a time: accepted when the model is idle and a
  // request is present, acknowledged L cycles later. Reads take the memory
  // contents at acceptance (nothing else can write in between).
  logic [31:0] mem_m [int];
  logic [31:0] exp_q[$];
  bit          exp_known_q[$];
  int          cyc = 0;
  bit          fl = 0;
  int          ack_cyc = 0;
  logic        m_we = 1'b0;
  int          m_idx = 0;
  logic [31:0] m_wdata = '0;
  bit          m_mis = 0;
  logic [31:0] last_rd = '0;
  bit          rd_known = 1;
  bit          e_ack;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      fl = 0;
      last_rd = '0;
      rd_known = 1;
      exp_q.delete();
      exp_known_q.delete();
      check("m_rst_ack", {31'd0, ack}, 32'd0);
      check("m_rst_busy", {31'd0, busy}, 32'd0);
      check("m_rst_rdata", rdata, 32'd0);
    end else begin
      e_ack = fl && (cyc == ack_cyc);
      check("m_ack", {31'd0, ack}, {31'd0, e_ack});
      check("m_busy", {31'd0, busy}, {31'd0, fl});
      check("m_stall", {31'd0, stall}, {31'd0, req & ~e_ack});
      if (e_ack) begin
        if (!m_we) begin
          if (exp_q.size() > 0) begin
            last_rd  = exp_q.pop_front();
            rd_known = exp_known_q.pop_front();
          end
        end else if (!m_mis) begin
          mem_m[m_idx] = m_wdata;
        end
`ifdef DMEM_ALIGN_CHECK_EN
        check("m_misalign", {31'd0, mis}, {31'd0, m_mis});
`endif
        fl = 0;
      end
`ifdef DMEM_ALIGN_CHECK_EN
      else begin
        check("m_misalign_idle", {31'd0, mis}, 32'd0);
      end
`endif
      if (rd_known) check("m_rdata", rdata, last_rd);
      if (!fl && !e_ack && req) begin
        fl      = 1;
        ack_cyc = cyc + L;
        m_we    = we;
        m_idx   = int'((addr >> 2) % 256);
        m_wdata = wdata;
`ifdef DMEM_ALIGN_CHECK_EN
        m_mis   = (addr % 4) != 0;
`else
        m_mis   = 0;
`endif
        if (!we) begin
          if (mem_m.exists(m_idx)) begin
            exp_q.push_back(mem_m[m_idx]);
            exp_known_q.push_back(1'b1);
          end else begin
            exp_q.push_back('0);
            exp_known_q.push_back(1'b0);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // mode 0: hold inputs; 1: scramble inputs after acceptance; 2: drop req
  // after acceptance. Called at posedge+1 with the DUT idle.
  task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input int mode, output logic [31:0] rd, output int lat,
                           output int st_cnt, output bit mis_o);
    bit got;
    got = 0; lat = -1; st_cnt = 0; rd = '0; mis_o = 0;
    req = 1'b1; we = w; addr = a; wdata = d;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (stall) st_cnt++;
      if (ack) begin
        got = 1; lat = k; rd = rdata;
`ifdef DMEM_ALIGN_CHECK_EN
        mis_o = mis;
`endif
      end
      if (!got && k == 0 && mode != 0) begin
        @(posedge clk); #1;
        if (mode == 1) begin
          addr = 32'h14; wdata = 32'hBADBAD00; we = ~w;
        end else begin
          req = 1'b0;
        end
      end
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL ack_timeout: no ack within 40 cycles for addr 0x%08h", a);
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] rd;
  int          lat, stc;
  bit          mo;
  int          a1 [2];
  int          a4 [2];
  int          na1, na4;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset then idle
    repeat (5) begin
      @(negedge clk);
      check("idle_ack", {31'd0, ack}, 32'd0);
      check("idle_stall", {31'd0, stall}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_rdata", rdata, 32'd0);
    end
    @(posedge clk); #1;

    // Write then read back
    do_access(1'b1, 32'h10, 32'hDEADBEEF, 0, rd, lat, stc, mo);
    check("wr_latency", lat, 32'd2);
    check("wr_stall_cycles", stc, 32'd2);
    do_access(1'b0, 32'h10, 32'h0, 0, rd, lat, stc, mo);
    check("rd_latency", lat, 32'd2);
    check("rd_data_0x10", rd, 32'hDEADBEEF);

    // Inputs scrambled during WAIT
    do_access(1'b1, 32'h14, 32'h11111111, 0, rd, lat, stc, mo);
    do_access(1'b1, 32'h18, 32'h22222222, 1, rd, lat, stc, mo);
    do_access(1'b0, 32'h14, 32'h0, 0, rd, lat, stc, mo);
    check("rd_data_0x14_prior", rd, 32'h11111111);
    do_access(1'b0, 32'h18, 32'h0, 0, rd, lat, stc, mo);
    check("rd_data_0x18", rd, 32'h22222222);

    // Request dropped during WAIT still completes
    do_access(1'b1, 32'h1C, 32'h33333333, 2, rd, lat, stc, mo);
    check("drop_latency", lat, 32'd2);
    do_access(1'b0, 32'h1C, 32'h0, 0, rd, lat, stc, mo);
    check("rd_data_0x1c", rd, 32'h33333333);

    // Reset in WAIT of a write
    do_access(1'b1, 32'h20, 32'h0000AAAA, 0, rd, lat, stc, mo);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h12345678;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0; req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_no_ack", {31'd0, ack}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_access(1'b0, 32'h20, 32'h0, 0, rd, lat, stc, mo);
    check("rd_after_abort", rd, 32'h0000AAAA);

`ifdef DMEM_ALIGN_CHECK_EN
    do_access(1'b1, 32'h22, 32'h55, 0, rd, lat, stc, mo);
    check("misalign_flag", {31'd0, mo}, 32'd1);
    check("misalign_latency", lat, 32'd2);
    do_access(1'b0, 32'h20, 32'h0, 0, rd, lat, stc, mo);
    check("misalign_no_write", rd, 32'h0000AAAA);
    check("aligned_no_flag", {31'd0, mo}, 32'd0);
`else
    // Low bits ignored and upper bits alias (0x420 -> word 8)
    do_access(1'b1, 32'h23, 32'h00000077, 0, rd, lat, stc, mo);
    do_access(1'b0, 32'h420, 32'h0, 0, rd, lat, stc, mo);
    check("alias_rd_0x420", rd, 32'h00000077);
`endif

    // LATENCY=1 / LATENCY=4: acceptance-to-ack and back-to-back spacing
    na1 = 0; na4 = 0;
    req_a = 1'b1; req_b = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ack_a && na1 < 2) begin a1[na1] = k; na1++; end
      if (ack_b && na4 < 2) begin a4[na4] = k; na4++; end
    end
    @(posedge clk); #1;
    req_a = 1'b0; req_b = 1'b0;
    check("l1_ack_count", na1, 32'd2);
    check("l4_ack_count", na4, 32'd2);
    if (na1 == 2) begin
      check("l1_latency", a1[0], 32'd1);
      check("l1_spacing", a1[1] - a1[0], 32'd2);
    end
    if (na4 == 2) begin
      check("l4_latency", a4[0], 32'd4);
      check("l4_spacing", a4[1] - a4[0], 32'd5);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
